// File: rtl/ps2_sprite_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared constants for the PS/2-driven sprite controller: scan codes,
// decoder state encoding, KEY_HELD bit positions and default geometry.
package ps2_sprite_ctrl_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    localparam int unsigned HELD_UP    = 3;
    localparam int unsigned HELD_DOWN  = 2;
    localparam int unsigned HELD_LEFT  = 1;
    localparam int unsigned HELD_RIGHT = 0;

    localparam int unsigned DEF_H_ACT = 800;
    localparam int unsigned DEF_V_ACT = 600;
    localparam int unsigned DEF_SPR_W = 256;
    localparam int unsigned DEF_SPR_H = 128;
    localparam int unsigned DEF_STEP  = 4;

    // One-hot KEY_HELD mask for an extended arrow code, zero for anything else
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] mask;
        mask = '0;
        case (code)
            SC_UP:    mask[HELD_UP]    = 1'b1;
            SC_DOWN:  mask[HELD_DOWN]  = 1'b1;
            SC_LEFT:  mask[HELD_LEFT]  = 1'b1;
            SC_RIGHT: mask[HELD_RIGHT] = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
`timescale 1ns/1ps
// PS/2 scan-code decoder: tracks held arrow keys from E0-prefixed make/break
// sequences and latches a recenter request on the space make code.
module ps2_scan_decoder
    import ps2_sprite_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_stb,
    input  logic [7:0] key_data,
    input  logic       recenter_clr,
    output logic [3:0] key_held,
    output logic       recenter_req
);

    dec_state_t state;
    dec_state_t state_next;
    logic [3:0] held_set;
    logic [3:0] held_clr;
    logic       space_hit;
    logic [3:0] mask;

    assign mask = arrow_mask(key_data);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DEC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: advance only on a received byte
    always_comb begin
        state_next = state;
        if (key_stb) begin
            case (state)
                DEC_IDLE: begin
                    if (key_data == SC_EXT)      state_next = DEC_EXT;
                    else if (key_data == SC_BRK) state_next = DEC_BRK;
                    else                         state_next = DEC_IDLE;
                end
                DEC_EXT: begin
                    if (mask != '0)              state_next = DEC_IDLE;
                    else if (key_data == SC_BRK) state_next = DEC_EXT_BRK;
                    else if (key_data == SC_EXT) state_next = DEC_EXT;
                    else                         state_next = DEC_IDLE;
                end
                DEC_BRK:     state_next = DEC_IDLE;
                DEC_EXT_BRK: state_next = DEC_IDLE;
                default:     state_next = DEC_IDLE;
            endcase
        end
    end

    // Outputs of the FSM: held-bit set/clear masks and the space hit
    always_comb begin
        held_set  = '0;
        held_clr  = '0;
        space_hit = 1'b0;
        if (key_stb) begin
            case (state)
                DEC_IDLE:    space_hit = (key_data == SC_SPACE);
                DEC_EXT:     held_set  = mask;
                DEC_EXT_BRK: held_clr  = mask;
                default:     ;
            endcase
        end
    end

    // Held-key register
    always_ff @(posedge clk) begin
        if (rst) begin
            key_held <= '0;
        end else begin
            key_held <= (key_held & ~held_clr) | held_set;
        end
    end

    // Recenter request: a space in the same cycle as the frame clear wins,
    // so that request survives to the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            recenter_req <= 1'b0;
        end else if (space_hit) begin
            recenter_req <= 1'b1;
        end else if (recenter_clr) begin
            recenter_req <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_sprite_ctrl.sv
`timescale 1ns/1ps
// Sprite position controller: per-frame move of the sprite top-left corner
// from held arrow keys, clamped to the visible area, with recenter on space.
module ps2_sprite_ctrl
    import ps2_sprite_ctrl_pkg::*;
#(
    parameter int unsigned H_ACT = DEF_H_ACT,
    parameter int unsigned V_ACT = DEF_V_ACT,
    parameter int unsigned SPR_W = DEF_SPR_W,
    parameter int unsigned SPR_H = DEF_SPR_H,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic        CLK_40M,
    input  logic        RST,
    input  logic        KEY_STB,
    input  logic [7:0]  KEY_DATA,
    input  logic        FRAME_STB,
    output logic [10:0] SPR_X,
    output logic [9:0]  SPR_Y,
    output logic [3:0]  KEY_HELD,
    output logic        EDGE_HIT
);

    localparam logic [11:0] X_MAX  = 12'(H_ACT - SPR_W);
    localparam logic [10:0] Y_MAX  = 11'(V_ACT - SPR_H);
    localparam logic [11:0] X_STEP = 12'(STEP);
    localparam logic [10:0] Y_STEP = 11'(STEP);
    localparam logic [10:0] X_CTR  = 11'((H_ACT - SPR_W) / 2);
    localparam logic [9:0]  Y_CTR  = 10'((V_ACT - SPR_H) / 2);

    logic        recenter_req;
    logic [11:0] x_wide;
    logic [10:0] y_wide;
    logic [10:0] x_next;
    logic [9:0]  y_next;
    logic        x_sat;
    logic        y_sat;

    ps2_scan_decoder u_decoder (
        .clk          (CLK_40M),
        .rst          (RST),
        .key_stb      (KEY_STB),
        .key_data     (KEY_DATA),
        .recenter_clr (FRAME_STB),
        .key_held     (KEY_HELD),
        .recenter_req (recenter_req)
    );

    // X candidate: one bit wider so a borrow below zero shows in the MSB
    always_comb begin
        x_wide = {1'b0, SPR_X};
        x_next = SPR_X;
        x_sat  = 1'b0;
        if (KEY_HELD[HELD_LEFT] && !KEY_HELD[HELD_RIGHT]) begin
            x_wide = {1'b0, SPR_X} - X_STEP;
            if (x_wide[11]) begin
                x_next = '0;
                x_sat  = 1'b1;
            end else begin
                x_next = x_wide[10:0];
            end
        end else if (KEY_HELD[HELD_RIGHT] && !KEY_HELD[HELD_LEFT]) begin
            x_wide = {1'b0, SPR_X} + X_STEP;
            if (x_wide > X_MAX) begin
                x_next = X_MAX[10:0];
                x_sat  = 1'b1;
            end else begin
                x_next = x_wide[10:0];
            end
        end
    end

    // Y candidate: up decreases, down increases
    always_comb begin
        y_wide = {1'b0, SPR_Y};
        y_next = SPR_Y;
        y_sat  = 1'b0;
        if (KEY_HELD[HELD_UP] && !KEY_HELD[HELD_DOWN]) begin
            y_wide = {1'b0, SPR_Y} - Y_STEP;
            if (y_wide[10]) begin
                y_next = '0;
                y_sat  = 1'b1;
            end else begin
                y_next = y_wide[9:0];
            end
        end else if (KEY_HELD[HELD_DOWN] && !KEY_HELD[HELD_UP]) begin
            y_wide = {1'b0, SPR_Y} + Y_STEP;
            if (y_wide > Y_MAX) begin
                y_next = Y_MAX[9:0];
                y_sat  = 1'b1;
            end else begin
                y_next = y_wide[9:0];
            end
        end
    end

    // Frame update of the position and the one-cycle clamp indicator
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            SPR_X    <= X_CTR;
            SPR_Y    <= Y_CTR;
            EDGE_HIT <= 1'b0;
        end else begin
            EDGE_HIT <= 1'b0;
            if (FRAME_STB) begin
                if (recenter_req) begin
                    SPR_X <= X_CTR;
                    SPR_Y <= Y_CTR;
                end else begin
                    SPR_X    <= x_next;
                    SPR_Y    <= y_next;
                    EDGE_HIT <= x_sat | y_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_sprite_ctrl.sv
`timescale 1ns/1ps
// Bench for ps2_sprite_ctrl: directed sequences then random byte/frame mix,
// compared against a prefix-queue and integer-arithmetic reference model.
module tb_ps2_sprite_ctrl;

    localparam int H_ACT = 800;
    localparam int V_ACT = 600;
    localparam int SPR_W = 256;
    localparam int SPR_H = 128;
    localparam int STEP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_stb = 1'b0;
    logic [7:0]  key_data = '0;
    logic        frame_stb = 1'b0;
    logic [10:0] spr_x;
    logic [9:0]  spr_y;
    logic [3:0]  key_held;
    logic        edge_hit;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         mx, my, medge;
    logic [3:0] mheld;
    bit         mrec;
    logic [7:0] pre[$];

    logic [7:0] codes [12] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72,
                               8'h6B, 8'h74, 8'h29, 8'h1C, 8'h75, 8'h6B};

    ps2_sprite_ctrl #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .STEP  (STEP)
    ) dut (
        .CLK_40M   (clk),
        .RST       (rst),
        .KEY_STB   (key_stb),
        .KEY_DATA  (key_data),
        .FRAME_STB (frame_stb),
        .SPR_X     (spr_x),
        .SPR_Y     (spr_y),
        .KEY_HELD  (key_held),
        .EDGE_HIT  (edge_hit)
    );

    always #12 clk = ~clk;

    function automatic logic [3:0] key_bit(input logic [7:0] b);
        case (b)
            8'h75:   return 4'b1000;
            8'h72:   return 4'b0100;
            8'h6B:   return 4'b0010;
            8'h74:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        mx = (H_ACT - SPR_W) / 2;
        my = (V_ACT - SPR_H) / 2;
        medge = 0;
        mheld = '0;
        mrec = 1'b0;
        pre.delete();
    endtask

    // Decoder behaviour described by the pending prefix bytes
    task automatic model_byte(input logic [7:0] b);
        if (pre.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pre.push_back(b);
            else if (b == 8'h29) mrec = 1'b1;
        end else if (pre.size() == 1 && pre[0] == 8'hE0) begin
            if (key_bit(b) != 0) begin
                mheld = mheld | key_bit(b);
                pre.delete();
            end else if (b == 8'hF0) begin
                pre.push_back(b);
            end else if (b != 8'hE0) begin
                pre.delete();
            end
        end else if (pre.size() == 1) begin
            pre.delete();
        end else begin
            mheld = mheld & ~key_bit(b);
            pre.delete();
        end
    endtask

    task automatic model_frame();
        int dx, dy, wx, wy;
        if (mrec) begin
            mx = (H_ACT - SPR_W) / 2;
            my = (V_ACT - SPR_H) / 2;
            mrec = 1'b0;
            medge = 0;
        end else begin
            dx = int'(mheld[0]) - int'(mheld[1]);
            dy = int'(mheld[2]) - int'(mheld[3]);
            wx = mx + dx * STEP;
            wy = my + dy * STEP;
            mx = clamp(wx, H_ACT - SPR_W);
            my = clamp(wy, V_ACT - SPR_H);
            medge = (mx != wx || my != wy) ? 1 : 0;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int edge_exp);
        check({tag, ".x"}, int'(spr_x), mx);
        check({tag, ".y"}, int'(spr_y), my);
        check({tag, ".held"}, int'(key_held), int'(mheld));
        check({tag, ".edge"}, int'(edge_hit), edge_exp);
    endtask

    // Drive one cycle of strobes, then sample 1 ns after the capturing edge
    task automatic cycle(input bit kstb, input logic [7:0] b, input bit fstb);
        @(posedge clk);
        #1;
        key_stb = kstb;
        key_data = b;
        frame_stb = fstb;
        @(posedge clk);
        #1;
        key_stb = 1'b0;
        frame_stb = 1'b0;
        if (fstb) model_frame();
        if (kstb) model_byte(b);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
        check("byte", int'(key_held), int'(mheld));
    endtask

    task automatic frame(input string tag);
        cycle(1'b0, 8'h00, 1'b1);
        check_all(tag, medge);
        @(posedge clk);
        #1;
        check({tag, ".edge_pulse"}, int'(edge_hit), 0);
    endtask

    task automatic both(input string tag, input logic [7:0] b);
        cycle(1'b1, b, 1'b1);
        check_all(tag, medge);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        check_all("reset", 0);
        frame("idle_frame");

        send(8'hE0); send(8'h74);
        check("right_held", int'(key_held), 1);
        for (int i = 0; i < 3; i++) frame("right");
        check("right_x", int'(spr_x), 284);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("right_rel", int'(key_held), 0);
        frame("after_rel");

        send(8'hE0); send(8'h6B);
        for (int i = 0; i < 75; i++) frame("left_run");
        check("left_floor", int'(spr_x), 0);

        send(8'hE0); send(8'h74);
        for (int i = 0; i < 5; i++) frame("lr_both");
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hE0); send(8'h72);
        for (int i = 0; i < 65; i++) frame("down_run");
        check("down_ceil", int'(spr_y), 472);
        send(8'hE0); send(8'hF0); send(8'h72);

        send(8'h29);
        frame("recenter");
        check("recenter_x", int'(spr_x), 272);
        send(8'hE0); send(8'h75);
        frame("up_once");
        both("space_coinc", 8'h29);
        frame("space_next");
        check("space_next_y", int'(spr_y), 236);

        send(8'hE0); send(8'h74);
        both("arrow_coinc", 8'h72);
        frame("arrow_after");

        send(8'hE0);
        do_reset();
        check_all("mid_reset", 0);
        send(8'h74);
        check("stray_byte", int'(key_held), 0);
        send(8'hE0); send(8'h6B);
        send(8'hF0); send(8'h6B);
        check("nonext_rel", int'(key_held), 2);
        frame("nonext_frame");

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 12) send(codes[$urandom_range(0, 11)]);
            else if (r < 17) frame("rand_frame");
            else if (r < 19) both("rand_both", codes[$urandom_range(0, 11)]);
            else begin
                do_reset();
                check_all("rand_reset", 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
